// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: buffers the two previous image rows and
// presents each complete 3x3 neighbourhood of a raster pixel stream.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     win_valid,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic [CW-1:0]            w_col;
  logic [RW-1:0]            w_row;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_emit;
  logic signed [DATA_W-1:0] r_lb1 [IMG_W];
  logic signed [DATA_W-1:0] r_lb2 [IMG_W];
  logic signed [DATA_W-1:0] r_win [9];
  logic signed [DATA_W-1:0] w_win [9];
  logic signed [DATA_W-1:0] r_out [9];
  logic                     r_win_valid;
  logic                     r_frame_done;

  // A pixel carrying sof is (0,0) whatever the counters currently say.
  always_comb begin
    w_col      = sof ? '0 : r_col;
    w_row      = sof ? '0 : r_row;
    w_last_col = (w_col == CW'(IMG_W - 1));
    w_last_row = (w_row == RW'(IMG_H - 1));
    w_emit     = pix_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  end

  always_comb begin
    w_win[0] = r_win[1];
    w_win[1] = r_win[2];
    w_win[2] = r_lb2[w_col];
    w_win[3] = r_win[4];
    w_win[4] = r_win[5];
    w_win[5] = r_lb1[w_col];
    w_win[6] = r_win[7];
    w_win[7] = r_win[8];
    w_win[8] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_win_valid  <= w_emit;
      r_frame_done <= pix_valid && w_last_col && w_last_row;
      if (pix_valid) begin
        r_col <= w_last_col ? '0 : w_col + 1'b1;
        if (w_last_col)
          r_row <= w_last_row ? '0 : w_row + 1'b1;
        else
          r_row <= w_row;
        r_win <= w_win;
        if (w_emit)
          r_out <= w_win;
      end
    end
  end

  // Line buffers are never read for an emitted window before being rewritten,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb2[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= pix_in;
    end
  end

  assign win0       = r_out[0];
  assign win1       = r_out[1];
  assign win2       = r_out[2];
  assign win3       = r_out[3];
  assign win4       = r_out[4];
  assign win5       = r_out[5];
  assign win6       = r_out[6];
  assign win7       = r_out[7];
  assign win8       = r_out[8];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution engine. It accepts a raster-order pixel stream, buffers the two previous image rows, and presents each complete 3x3 neighbourhood as nine parallel signed pixels. A one-cycle write strobe accompanies each window and drives the engine's feature-map write enable `if_w`. The convolution is valid-only, with no padding.

## Interface
- `DATA_W`, default 8: pixel width; equals `Pixel_DataSize`.
- `IMG_W`, default 8: pixels per row; legal range is 3 or more.
- `IMG_H`, default 8: rows per frame; legal range is 3 or more.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pix_in`  in  DATA_W signed  incoming pixel, raster order (row-major, column 0 first).
- `pix_valid`  in  1  `pix_in` is accepted on this edge; there is no backpressure.
- `sof`  in  1  start of frame; only meaningful together with `pix_valid`.
- `win0`..`win8`  out  DATA_W signed each  window pixels; connect to `if_in0`..`if_in8`.
- `win_valid`  out  1  one-cycle strobe marking a new window; connect to `if_w`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- **Position counters.**
  - `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1.
  - Both advance only on accepted pixels (`pix_valid`=1).
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after (IMG_H-1, IMG_W-1), and the next pixel starts a new frame.
- **sof handling.**
  - `sof`=1 with `pix_valid`=1: that pixel is (0,0) regardless of counter state; counters resync, and the next pixel is (0,1).
  - `sof` without `pix_valid` is ignored.
- **Line buffers.**
  - Two buffers, each IMG_W entries deep, hold rows r-1 and r-2, indexed by column.
  - On accept, the pixel at column c is written to the row r-1 buffer.
  - The old row r-1 entry at column c moves to the row r-2 buffer.
- **Window registers.**
  - A 3x3 register array shifts left by one column on each accept.
  - New right column, top to bottom: row-2 buffer[c], row-1 buffer[c], `pix_in`. These are the values read before the update.
- **Output mapping.** For the pixel accepted at (r,c):
  - `win0`,`win1`,`win2` = (r-2,c-2), (r-2,c-1), (r-2,c)
  - `win3`,`win4`,`win5` = (r-1,c-2), (r-1,c-1), (r-1,c)
  - `win6`,`win7`,`win8` = (r,c-2), (r,c-1), (r,c)
- **Window emission.** A window is emitted only when r≥2 and c≥2, giving (IMG_W-2)*(IMG_H-2) windows per frame.
  - Windows never straddle a row wrap.
  - The left columns that are stale after a wrap are not emitted, because c<2 there.
- **Arithmetic.** Pixels pass through unmodified as signed two's-complement values, with no arithmetic.

## Timing
- **Reset values.** After `rst`=1, all of the following are 0 on the next edge and stay 0 while `rst` is held:
  - `win0`..`win8`, `win_valid`, `frame_done`, `col`, `row`, and the window registers.
  - Line-buffer contents need not be cleared: they are never emitted before being rewritten.
- **Latency.** The pixel accepted on edge k produces outputs on edge k:
  - `win*` and `win_valid` are registered and visible in the cycle after edge k.
  - `win_valid` is high for exactly that one cycle.
  - `win*` hold their value until the next emitted window.
- **Downstream timing.** The engine captures the window on edge k+1, and its combinational `out` is valid during the cycle after k+1.
- **Gaps.** With `pix_valid`=0, nothing changes except that `win_valid` and `frame_done` deassert. Arbitrary gaps are legal.
- **frame_done.** Pulses in the same cycle as the `win_valid` of pixel (IMG_H-1, IMG_W-1).
- **Back-to-back frames.** The first pixel of frame n+1 may be accepted on the edge immediately after the last pixel of frame n.
- **Reset mid-frame.** The partial frame is discarded, no window is emitted for it, and the next accepted pixel is (0,0).
- **Mid-frame sof.** A `sof` during a frame aborts that frame silently: no `frame_done` is issued for it.
- **sof with rst.** When `sof` and `rst` are both high, `rst` wins.

## Test plan
- **Ramp image.** 8x8 frame, pix = 8r+c, continuous `pix_valid` -> exactly 36 `win_valid` pulses.
  - First window (after pixel 18): `win0`..`win8` = 0,1,2,8,9,10,16,17,18.
  - Last window: 45,46,47,53,54,55,61,62,63.
  - `frame_done` coincides with the last window.
- **Gaps.** Same frame with `pix_valid` toggling pseudo-randomly (about 50%) -> identical 36 windows in the same order; no `win_valid` during gaps.
- **Signed extremes.** All pixels -128, except (3,3)=127 -> the window for pixel (3,3) has `win8`=127 and all other entries -128.
  - Connected engine with all weights 1: `out` = 127 - 8·128 = -897.
- **Back-to-back frames with reset.** Two frames back-to-back (second frame pix = 63-(8r+c)) -> 72 windows, 2 `frame_done` pulses; the first window of frame 2 is 63,62,61,55,54,53,47,46,45.
  - Assert `rst` for one cycle at pixel 30 of a third frame, then send a fresh frame -> 36 correct windows from the fresh frame; none from the aborted one.
- **Mid-frame sof.** Assert `sof` at pixel 20 of a frame, then stream a full ramp frame -> no `frame_done` for the aborted frame; the new frame yields 36 windows, the first equal to 0,1,2,8,9,10,16,17,18.
